// File: rtl/bitwise_op_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit AND/OR/XOR/NOR unit.
// One operation in flight at a time: accept in IDLE, compute in EXEC, hold the result in RESP.
module bitwise_op_arbiter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               id_q, id_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic               rsp_id_q, rsp_id_d;
   logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
   logic               grant_vld, grant_id;

   function automatic logic [WIDTH-1:0] bit_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   bit_op = a & b;
         2'b01:   bit_op = a | b;
         2'b10:   bit_op = a ^ b;
         default: bit_op = ~(a | b);
      endcase
   endfunction

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state_q == IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant_q;
         end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
         end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign req0_ready = grant_vld && !grant_id;
   assign req1_ready = grant_vld && grant_id;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      done_cnt_d   = done_cnt_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               op_d         = grant_id ? req1_op : req0_op;
               a_d          = grant_id ? req1_a  : req0_a;
               b_d          = grant_id ? req1_b  : req0_b;
               id_d         = grant_id;
               last_grant_d = grant_id;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = bit_op(op_q, a_q, b_q);
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               done_cnt_d  = done_cnt_q + CNT_W'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= 1'b0;
         done_cnt_q   <= '0;
         id_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         done_cnt_q   <= done_cnt_d;
         id_q         <= id_d;
      end
   end

   // Operand latches need no reset: they are only consumed after an accept.
   always_ff @(posedge clk) begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);
   assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Directed and randomized checks of bitwise_op_arbiter against a transaction-level model.
module tb_bitwise_op_arbiter;
   localparam int W  = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [1:0]    req0_op, req1_op;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          rsp_valid, rsp_ready, rsp_id, busy;
   logic [W-1:0]  rsp_data;
   logic [CW-1:0] done_cnt;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   bitwise_op_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .busy(busy), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Present a request and wait (bounded) for the accept edge; returns just after it.
   task automatic issue(input int n, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      bit ok = 0;
      if (n == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         ok = (n == 0) ? req0_ready : req1_ready;
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic run_op(input string tag, input int n, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
      rsp_ready = 1'b1;
      issue(n, op, a, b);
      chk({tag, "_busy_exec"}, busy, 1);
      chk({tag, "_valid_exec"}, rsp_valid, 0);
      tick();
      chk({tag, "_valid"}, rsp_valid, 1);
      chk({tag, "_data"}, rsp_data, exp);
      chk({tag, "_id"}, rsp_id, n);
      tick();
      chk({tag, "_valid_after"}, rsp_valid, 0);
      chk({tag, "_idle_after"}, busy, 0);
   endtask

   // Transaction-level model state for the random phase
   bit           m_busy, m_exec, m_rv, m_last, m_id, acc, hs, gid, exp_r0, exp_r1;
   logic [W-1:0] m_data, acc_data;
   int           m_cnt;

   initial begin
      int got;
      bit both_hi, stable, leak;
      logic [W-1:0] exp_data;
      logic [W-1:0] ops_exp[4];

      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      tick(); tick();

      // Reset state, readies held low while rst is high
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_cnt", done_cnt, 0);
      req0_valid = 0; req1_valid = 0;
      rst = 1'b0;

      // Reset mid-operation
      issue(0, 2'd1, 32'h1234_0000, 32'h0000_5678);
      chk("midrst_exec", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_cnt", done_cnt, 0);
      leak = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rsp_valid || busy) leak = 1;
      end
      chk("midrst_no_rsp", leak, 0);

      // Single OR from requester 0
      run_op("or0", 0, 2'd1, 32'hFFFF_0000, 32'h0000_FF00, 32'hFFFF_FF00);
      chk("or0_cnt", done_cnt, 1);

      // All ops from requester 1
      do_reset();
      ops_exp = '{32'h000F_0000, 32'hFFFF_00FF, 32'hFFF0_00FF, 32'h0000_FF00};
      for (int k = 0; k < 4; k++)
         run_op($sformatf("op%0d_r1", k), 1, 2'(k), 32'hFFFF_0000, 32'h000F_00FF, ops_exp[k]);
      chk("ops_cnt", done_cnt, 4);

      // Contention: both valid continuously, grants alternate starting with 0
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1; req0_op = 2'd1; req0_a = 32'h000F_0000; req0_b = 32'h000F_00FF;
      req1_valid = 1; req1_op = 2'd0; req1_a = 32'hFFFF_0000; req1_b = 32'hFFFF_0000;
      got = 0; both_hi = 0;
      for (int i = 0; i < 40 && got < 4; i++) begin
         #1;
         if (req0_ready && req1_ready) both_hi = 1;
         if (rsp_valid) begin
            chk($sformatf("cont_id%0d", got), rsp_id, got % 2);
            chk($sformatf("cont_data%0d", got), rsp_data,
                (got % 2) ? 32'hFFFF_0000 : 32'h000F_00FF);
            got++;
         end
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      chk("cont_count", got, 4);
      chk("cont_both_ready", both_hi, 0);

      // Backpressure in RESP
      do_reset();
      rsp_ready = 1'b0;
      issue(0, 2'd2, 32'h1234_5678, 32'hFFFF_0000);
      tick();
      req0_valid = 1; req1_valid = 1;
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (rsp_valid !== 1 || rsp_data !== 32'hEDCB_5678 || rsp_id !== 0 ||
             req0_ready !== 0 || req1_ready !== 0 || busy !== 1) stable = 0;
         tick();
      end
      chk("bp_stable", stable, 1);
      chk("bp_data", rsp_data, 32'hEDCB_5678);
      req0_valid = 0; req1_valid = 0;
      rsp_ready = 1'b1;
      tick();
      chk("bp_valid_rel", rsp_valid, 0);
      chk("bp_idle_rel", busy, 0);
      chk("bp_data_hold", rsp_data, 32'hEDCB_5678);
      chk("bp_cnt", done_cnt, 1);

      // Operand change after accept
      do_reset();
      issue(0, 2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      req0_a = 32'h0; req0_op = 2'd3; req0_valid = 1;
      tick();
      chk("latch_data", rsp_data, 32'hF000_F000);
      req0_valid = 0;
      tick();

      // Counter wrap with CNT_W=4
      do_reset();
      for (int k = 0; k < 15; k++) begin
         exp_data = $urandom;
         run_op($sformatf("wrap%0d", k), k % 2, 2'd1, exp_data, 32'h0, exp_data);
      end
      chk("wrap_cnt15", done_cnt, 15);
      run_op("wrap_last", 0, 2'd2, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
      chk("wrap_cnt0", done_cnt, 0);

      // Randomized traffic against the transaction model
      do_reset();
      m_busy = 0; m_exec = 0; m_rv = 0; m_last = 1; m_cnt = 0; acc = 0; hs = 0;
      m_data = '0; m_id = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (acc) begin
            m_busy = 1; m_exec = 1; m_last = gid; m_id = gid; m_data = acc_data;
         end else if (m_exec) begin
            m_exec = 0; m_rv = 1;
         end else if (hs) begin
            m_rv = 0; m_busy = 0; m_cnt = (m_cnt + 1) % 16;
         end
         chk("rnd_busy", busy, m_busy);
         chk("rnd_valid", rsp_valid, m_rv);
         chk("rnd_cnt", done_cnt, m_cnt);
         req0_valid = ($urandom_range(0, 9) < 6);
         req1_valid = ($urandom_range(0, 9) < 6);
         req0_op = 2'($urandom); req1_op = 2'($urandom);
         req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
         rsp_ready = ($urandom_range(0, 1) == 1);
         #1;
         exp_r0 = 0; exp_r1 = 0;
         if (!m_busy) begin
            if (req0_valid && req1_valid) begin
               exp_r0 = m_last; exp_r1 = !m_last;
            end else begin
               exp_r0 = req0_valid; exp_r1 = req1_valid;
            end
         end
         chk("rnd_ready0", req0_ready, exp_r0);
         chk("rnd_ready1", req1_ready, exp_r1);
         acc = exp_r0 || exp_r1;
         gid = exp_r1;
         acc_data = gid ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
         hs = m_rv && rsp_ready;
         if (hs) begin
            chk("rnd_data", rsp_data, m_data);
            chk("rnd_id", rsp_id, m_id);
         end
      end
      req0_valid = 0; req1_valid = 0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
